// File: rtl/branch_control_if.sv
// Interface between the ALU flags and opcode source and the branch-resolution unit.
// The master side drives the opcode and flags; the slave side returns branch_valid.
interface branch_control_if #(
    parameter int OPCODE_W = 6
);
    logic [OPCODE_W-1:0] opcode;
    logic                sign;
    logic                zero_flag;
    logic                carry;
    logic                branch_valid;

    modport master (
        output opcode,
        output sign,
        output zero_flag,
        output carry,
        input  branch_valid
    );

    modport slave (
        input  opcode,
        input  sign,
        input  zero_flag,
        input  carry,
        output branch_valid
    );
endinterface

// File: rtl/branch_control.sv
// KGP-miniRISC branch resolution: decodes the opcode against the ALU flags and
// registers a one-cycle-latency branch_valid strobe for the PC mux.
module branch_control #(
    parameter int OPCODE_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    branch_control_if.slave bus
);

    localparam logic [OPCODE_W-1:0] OP_BLTZ = OPCODE_W'(6'b000111);
    localparam logic [OPCODE_W-1:0] OP_BZ   = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_BNZ  = OPCODE_W'(6'b001001);
    localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(6'b001010);
    localparam logic [OPCODE_W-1:0] OP_B    = OPCODE_W'(6'b001011);
    localparam logic [OPCODE_W-1:0] OP_BL   = OPCODE_W'(6'b001100);
    localparam logic [OPCODE_W-1:0] OP_BCY  = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_BNCY = OPCODE_W'(6'b001110);

    logic taken;

    always_comb begin
        // NOTE: the default assignment before the case prevents an inferred latch,
        // and the default arm keeps unknown or non-branch opcodes from branching.
        taken = 1'b0;
        case (bus.opcode)
            OP_BLTZ:             taken = bus.sign;
            OP_BZ:               taken = bus.zero_flag;
            OP_BNZ:              taken = ~bus.zero_flag;
            OP_BR, OP_B, OP_BL:  taken = 1'b1;
            OP_BCY:              taken = bus.carry;
            OP_BNCY:             taken = ~bus.carry;
            default:             taken = 1'b0;
        endcase
    end

    // NOTE: non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.branch_valid <= 1'b0;
        end else begin
            bus.branch_valid <= taken;
        end
    end

endmodule

// File: tb/tb_branch_control.sv
// Directed, table-driven bench for branch_control: reset, each branch class,
// non-branch opcodes, mid-run reset and mid-cycle input changes.
module tb_branch_control;

    typedef struct {
        string      name;
        logic [5:0] opcode;
        logic       sign;
        logic       zero_flag;
        logic       carry;
        logic       rst;
        logic       expected;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[$];

    branch_control_if #(.OPCODE_W(6)) bus ();

    branch_control #(.OPCODE_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic [5:0] op, logic s, logic z, logic c,
                                logic r, logic e);
        vec_t v;
        v.name      = name;
        v.opcode    = op;
        v.sign      = s;
        v.zero_flag = z;
        v.carry     = c;
        v.rst       = r;
        v.expected  = e;
        return v;
    endfunction

    task automatic check(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst           = v.rst;
        bus.opcode    = v.opcode;
        bus.sign      = v.sign;
        bus.zero_flag = v.zero_flag;
        bus.carry     = v.carry;
        @(posedge clk);
        #1;
        check(v.name, bus.branch_valid, v.expected);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst           = 1'b0;
        bus.opcode    = 6'b001011;
        bus.sign      = 1'b0;
        bus.zero_flag = 1'b0;
        bus.carry     = 1'b0;

        // Reset held for two edges with an unconditional branch present, then released.
        apply(mk("reset_edge1",   6'b001011, 0, 0, 0, 0, 0));
        apply(mk("reset_edge2",   6'b001011, 0, 0, 0, 0, 0));
        apply(mk("reset_release", 6'b001011, 0, 0, 0, 1, 1));

        vecs.push_back(mk("bcy_c1",       6'b001101, 0, 0, 1, 1, 1));
        vecs.push_back(mk("bcy_c0",       6'b001101, 1, 1, 0, 1, 0));
        vecs.push_back(mk("bncy_c0",      6'b001110, 1, 1, 0, 1, 1));
        vecs.push_back(mk("bncy_c1",      6'b001110, 0, 0, 1, 1, 0));
        vecs.push_back(mk("bltz_s1",      6'b000111, 1, 0, 0, 1, 1));
        vecs.push_back(mk("bltz_s0_z1c1", 6'b000111, 0, 1, 1, 1, 0));
        vecs.push_back(mk("bz_z1",        6'b001000, 0, 1, 0, 1, 1));
        vecs.push_back(mk("bz_z0",        6'b001000, 1, 0, 1, 1, 0));
        vecs.push_back(mk("bnz_z0",       6'b001001, 1, 0, 1, 1, 1));
        vecs.push_back(mk("bnz_z1",       6'b001001, 0, 1, 0, 1, 0));
        vecs.push_back(mk("br_c0s1",      6'b001010, 1, 0, 0, 1, 1));
        vecs.push_back(mk("br_c1z0",      6'b001010, 0, 0, 1, 1, 1));
        vecs.push_back(mk("br_z1s1",      6'b001010, 1, 1, 0, 1, 1));
        vecs.push_back(mk("br_s0",        6'b001010, 0, 0, 0, 1, 1));
        vecs.push_back(mk("b_c0s1",       6'b001011, 1, 0, 0, 1, 1));
        vecs.push_back(mk("b_c1z0",       6'b001011, 0, 0, 1, 1, 1));
        vecs.push_back(mk("b_z1s1",       6'b001011, 1, 1, 0, 1, 1));
        vecs.push_back(mk("b_s0",         6'b001011, 0, 0, 0, 1, 1));
        vecs.push_back(mk("bl_c0s1",      6'b001100, 1, 0, 0, 1, 1));
        vecs.push_back(mk("bl_c1z0",      6'b001100, 0, 0, 1, 1, 1));
        vecs.push_back(mk("bl_z1s1",      6'b001100, 1, 1, 0, 1, 1));
        vecs.push_back(mk("bl_s0",        6'b001100, 0, 0, 0, 1, 1));
        vecs.push_back(mk("nop_000000",   6'b000000, 1, 1, 1, 1, 0));
        vecs.push_back(mk("op_111111",    6'b111111, 1, 1, 1, 1, 0));
        vecs.push_back(mk("op_001111",    6'b001111, 1, 1, 1, 1, 0));
        vecs.push_back(mk("op_000110",    6'b000110, 1, 1, 1, 1, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Mid-run reset during an unconditional branch, then recovery.
        apply(mk("pre_reset_b",   6'b001011, 0, 0, 0, 1, 1));
        apply(mk("midrun_reset",  6'b001011, 0, 0, 0, 0, 0));
        apply(mk("post_reset_bl", 6'b001100, 0, 0, 0, 1, 1));

        // Mid-cycle flag change must not disturb the registered output.
        apply(mk("bz_hold_setup", 6'b001000, 0, 1, 0, 1, 1));
        bus.zero_flag = 1'b0;
        #2;
        check("bz_hold_midcycle", bus.branch_valid, 1'b1);
        @(posedge clk);
        #1;
        check("bz_after_change", bus.branch_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
